galois_mult_serial: RTL and testbench



---
 rtl/galois_mult_serial.sv | 120 ++++++++++++
 tb/tb_galois_mult_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/galois_mult_serial.sv
// galois_mult_serial: sequential prime-field modular multiplier.
// product = (num1 * num2) mod PRIME, computed MSB-first by double-and-add.
// The caller loads the operands while rst is high and releases rst to start.
// The caller samples product once done is high.
// The optional macro GALOIS_MULT_RADIX4_EN consumes two multiplier bits per
// RUN cycle instead of one. The handshake and the results are identical
// in both builds.
module galois_mult_serial #(
    parameter int                N_BITS = 254,
    parameter logic [N_BITS-1:0] PRIME  = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] num1,
    input  logic [N_BITS-1:0] num2,
    output logic [N_BITS-1:0] product,
    output logic              done
);

`ifdef GALOIS_MULT_RADIX4_EN
    // Multiplier is zero-extended to an even width so bits pair up cleanly.
    localparam int B_W   = N_BITS + (N_BITS % 2);
    localparam int STEP  = 2;
    localparam int LAST  = 1;
`else
    localparam int B_W   = N_BITS;
    localparam int STEP  = 1;
    localparam int LAST  = 0;
`endif
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

    localparam logic [N_BITS:0]  PRIME_X  = {1'b0, PRIME};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(B_W - 1);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [N_BITS-1:0] a;
    logic [B_W-1:0]    b;
    logic [N_BITS-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [N_BITS-1:0] t_next;

    // One double-and-conditional-add step modulo PRIME. Both acc and a are
    // below PRIME, so one extra bit of headroom and one conditional
    // subtraction after each operation keep the result fully reduced.
    function automatic logic [N_BITS-1:0] mod_step(input logic [N_BITS-1:0] acc_in,
                                                   input logic [N_BITS-1:0] a_in,
                                                   input logic              bit_in);
        logic [N_BITS:0] t;
        t = {acc_in, 1'b0};
        if (t >= PRIME_X) t = t - PRIME_X;
        if (bit_in) begin
            t = t + {1'b0, a_in};
            if (t >= PRIME_X) t = t - PRIME_X;
        end
        return t[N_BITS-1:0];
    endfunction

    // The multiplicand is below 2*PRIME, so a single subtraction reduces it.
    function automatic logic [N_BITS-1:0] reduce_in(input logic [N_BITS-1:0] x);
        return (x >= PRIME) ? (x - PRIME) : x;
    endfunction

    // Next accumulator value for the multiplier bit(s) selected by cnt.
    always_comb begin
`ifdef GALOIS_MULT_RADIX4_EN
        logic [N_BITS-1:0] t_mid;
        t_mid  = mod_step(acc, a, b[cnt]);
        t_next = mod_step(t_mid, a, b[cnt - CNT_W'(1)]);
`else
        t_next = mod_step(acc, a, b[cnt]);
`endif
    end

    // Control FSM with a registered result. rst aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        a     <= reduce_in(num1);
                        b     <= B_W'(num2);
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        acc <= t_next;
                        if (cnt == CNT_LAST) begin
                            product <= t_next;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt - CNT_STEP;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_galois_mult_serial.sv
// Testbench for galois_mult_serial.
// The 8-bit (PRIME=251) instance is driven from a vector table plus
// hand-written stall, abort and hold sequences. The BN254 instance is
// driven from its own vector table.
module tb_galois_mult_serial;

    localparam logic [253:0] P254 = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

`ifdef GALOIS_MULT_RADIX4_EN
    localparam int LAT8      = 5;
    localparam int LAT254    = 128;
    localparam int STALL_LAT = 9;
`else
    localparam int LAT8      = 9;
    localparam int LAT254    = 255;
    localparam int STALL_LAT = 13;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, en8, done8;
    logic [7:0] n1_8, n2_8, prod8;

    logic         rst254, en254, done254;
    logic [253:0] n1_254, n2_254, prod254;

    galois_mult_serial #(.N_BITS(8), .PRIME(8'd251)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .num1(n1_8), .num2(n2_8),
        .product(prod8), .done(done8)
    );

    galois_mult_serial #(.N_BITS(254), .PRIME(P254)) dut254 (
        .clk(clk), .rst(rst254), .en(en254), .num1(n1_254), .num2(n2_254),
        .product(prod254), .done(done254)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
    } vec8_t;

    typedef struct {
        logic [253:0] a;
        logic [253:0] b;
        logic [253:0] p;
    } vec254_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Load operands under reset, then release reset with en high (called at a negedge).
    task automatic start8(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        rst8 = 1'b1; en8 = 1'b1; n1_8 = x; n2_8 = y;
        @(negedge clk);
        rst8 = 1'b0;
    endtask

    // Count edges until done. Edges sf..st (1-based) are stalled with
    // scrambled operands. lat = -1 on timeout.
    task automatic wait8(input int sf, input int st, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done8) begin
                lat = n;
                break;
            end
            en8 = !((n + 1) >= sf && (n + 1) <= st);
            if (!en8) begin
                n1_8 = 8'($urandom);
                n2_8 = 8'($urandom);
            end
        end
    endtask

    task automatic run254(input logic [253:0] x, input logic [253:0] y, output int lat);
        int n;
        @(negedge clk);
        rst254 = 1'b1; en254 = 1'b1; n1_254 = x; n2_254 = y;
        @(negedge clk);
        rst254 = 1'b0;
        n = 0;
        lat = -1;
        while (n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done254) begin
                lat = n;
                break;
            end
        end
    endtask

    vec8_t   v8[8];
    vec254_t v254[3];
    int      lat;

    initial begin
        v8[0] = '{8'd3,   8'd5,   8'd15};
        v8[1] = '{8'd250, 8'd250, 8'd1};
        v8[2] = '{8'd255, 8'd2,   8'd8};
        v8[3] = '{8'd0,   8'd200, 8'd0};
        v8[4] = '{8'd7,   8'd9,   8'd63};
        v8[5] = '{8'd255, 8'd255, 8'd16};
        v8[6] = '{8'd1,   8'd251, 8'd0};
        v8[7] = '{8'd10,  8'd30,  8'd49};

        v254[0] = '{P254 - 254'd1, P254 - 254'd1, 254'd1};
        v254[1] = '{254'd2,        P254 - 254'd1, P254 - 254'd2};
        v254[2] = '{254'd5,        254'd7,        254'd35};

        rst8 = 1'b1; en8 = 1'b0; n1_8 = '0; n2_8 = '0;
        rst254 = 1'b1; en254 = 1'b0; n1_254 = '0; n2_254 = '0;
        repeat (2) @(negedge clk);
        chk("reset done8", 256'(done8), 256'd0);
        chk("reset product8", 256'(prod8), 256'd0);
        chk("reset done254", 256'(done254), 256'd0);
        chk("reset product254", 256'(prod254), 256'd0);

        // While idle with en low, nothing starts.
        rst8 = 1'b0; en8 = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle no done", 256'(done8), 256'd0);

        for (int i = 0; i < 8; i++) begin
            start8(v8[i].a, v8[i].b);
            wait8(0, -1, lat);
            chk($sformatf("vec8[%0d] product", i), 256'(prod8), 256'(v8[i].p));
            chk($sformatf("vec8[%0d] latency", i), 256'(lat), 256'(LAT8));
        end

        for (int i = 0; i < 3; i++) begin
            run254(v254[i].a, v254[i].b, lat);
            chk($sformatf("vec254[%0d] product", i), 256'(prod254), 256'(v254[i].p));
            chk($sformatf("vec254[%0d] latency", i), 256'(lat), 256'(LAT254));
        end

        // Stall of four cycles mid-run, with operands scrambled while stalled.
        start8(8'd3, 8'd5);
        wait8(4, 7, lat);
        chk("stall product", 256'(prod8), 256'd15);
        chk("stall latency", 256'(lat), 256'(STALL_LAT));

        // Abort mid-run, then restart with new operands.
        en8 = 1'b1;
        start8(8'd3, 8'd5);
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        chk("abort done", 256'(done8), 256'd0);
        chk("abort product", 256'(prod8), 256'd0);
        n1_8 = 8'd7; n2_8 = 8'd9; en8 = 1'b1;
        rst8 = 1'b0;
        wait8(0, -1, lat);
        chk("restart product", 256'(prod8), 256'd63);
        chk("restart latency", 256'(lat), 256'(LAT8));

        // In DONE, en and operand activity must not disturb the result.
        for (int i = 0; i < 20; i++) begin
            en8 = 1'($urandom);
            n1_8 = 8'($urandom);
            n2_8 = 8'($urandom);
            @(negedge clk);
            chk("hold product", 256'(prod8), 256'd63);
            chk("hold done", 256'(done8), 256'd1);
        end
        rst8 = 1'b1;
        @(negedge clk);
        chk("hold exit done", 256'(done8), 256'd0);
        chk("hold exit product", 256'(prod8), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
